// File: rtl/isr_mem.sv
// isr_mem: writable ISR handler RAM with a fetch port, a byte-enabled loader port and a post-reset clear sequencer
// Ports:
//   clk                        system clock
//   rst                        synchronous, active-low reset
//   i_addr, i_stall -> inst    instruction fetch: registered address (held on stall), combinational read
//   d_addr, d_re, d_we,
//   d_wdata, d_wp   -> d_rdata, d_werr   loader port: byte-enabled writes, registered-address reads
//   ready                      high once the array has been zeroed after reset
// Optional: define ISR_MEM_WPROT_EN to discard writes requested while d_wp=1.
module isr_mem #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 30,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic                  i_stall,
   output logic [DATA_W-1:0]     inst,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic                  d_re,
   input  logic [DATA_W/8-1:0]   d_we,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic                  d_wp,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_werr,
   output logic                  ready
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int NB    = DATA_W/8;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, state_n;
   logic [DEPTH_LOG2-1:0] clr_ptr;
   logic [ADDR_W-1:0] i_addr_r, d_addr_r;
   logic [DATA_W-1:0] mem [DEPTH];
   logic run, d_oor, wp, wr_ok, wr_bad;
   assign run = state == RUN;
   assign ready = run;
   assign d_oor = (d_addr >> DEPTH_LOG2) != '0;
`ifdef ISR_MEM_WPROT_EN
   assign wp = d_wp;
`else
   assign wp = 1'b0 & d_wp;
`endif
   // a write that hits both the range check and write-protect still yields a single error pulse
   assign wr_bad = run && (|d_we) && (d_oor || wp);
   assign wr_ok  = rst && run && !d_oor && !wp;
   // the clear pass ends once the last index has been zeroed
   always_comb state_n = (state == CLEAR && &clr_ptr) ? RUN : state;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= CLEAR;
         clr_ptr  <= '0;
         i_addr_r <= '0;
         d_addr_r <= '0;
         d_werr   <= 1'b0;
      end else begin
         state    <= state_n;
         clr_ptr  <= run ? clr_ptr : clr_ptr + 1'b1;
         i_addr_r <= i_stall ? i_addr_r : i_addr;
         d_addr_r <= d_re ? d_addr : d_addr_r;
         d_werr   <= wr_bad;
      end
   end
   always_ff @(posedge clk) begin
      if (!run)
         mem[clr_ptr] <= '0;
      else if (wr_ok)
         for (int k = 0; k < NB; k++)
            if (d_we[k]) mem[d_addr[DEPTH_LOG2-1:0]][8*k +: 8] <= d_wdata[8*k +: 8];
   end
   // reads return zero until cleared and for addresses beyond the array
   assign inst    = (run && (i_addr_r >> DEPTH_LOG2) == '0) ? mem[i_addr_r[DEPTH_LOG2-1:0]] : '0;
   assign d_rdata = (run && (d_addr_r >> DEPTH_LOG2) == '0) ? mem[d_addr_r[DEPTH_LOG2-1:0]] : '0;
endmodule
